// File: rtl/thermo_dec.sv
// Thermometer-to-binary decoder with a two-stage valid/ready pipeline.
// Counts ones to tolerate bubbles and flags codes that are not 1..10..0.
module thermo_dec #(
  parameter int D_WIDTH   = 4,
  parameter int Q_WIDTH   = 2**D_WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [Q_WIDTH-1:0]   Q,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [D_WIDTH-1:0]   D,
  output logic                 ERR,
  input  logic                 ERR_CLR,
  output logic [CNT_WIDTH-1:0] ERR_CNT
);

  localparam logic [D_WIDTH:0]     QW   = (D_WIDTH+1)'(Q_WIDTH);
  localparam logic [D_WIDTH-1:0]   DMAX = D_WIDTH'(Q_WIDTH-1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [Q_WIDTH-1:0]   s1_q_q, s1_q_d;
  logic                 s1_v_q, s1_v_d;
  logic                 s1_legal_q, s1_legal_d;
  logic                 ov_q, ov_d;
  logic [D_WIDTH-1:0]   d_q, d_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 adv1, adv2;
  logic                 legal_in;
  logic [D_WIDTH:0]     pop, diff;
  logic [D_WIDTH-1:0]   dec;

  assign adv2 = ~ov_q | OUT_READY;
  assign adv1 = ~s1_v_q | adv2;

  // Legal: MSB set and no 1 sitting directly below a 0.
  assign legal_in = Q[Q_WIDTH-1] &
    ~|(Q[Q_WIDTH-2:0] & ~Q[Q_WIDTH-1:1]);

  always_comb begin
    pop = '0;
    for (int i = 0; i < Q_WIDTH; i++) begin
      pop = pop + (D_WIDTH+1)'(s1_q_q[i]);
    end
    diff = QW - pop;
    // diff reaches Q_WIDTH only for an all-zero code
    dec  = diff[D_WIDTH] ? DMAX : diff[D_WIDTH-1:0];
  end

  always_comb begin
    s1_q_d     = s1_q_q;
    s1_v_d     = s1_v_q;
    s1_legal_d = s1_legal_q;
    ov_d       = ov_q;
    d_d        = d_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (adv1) begin
      s1_v_d     = IN_VALID;
      s1_q_d     = Q;
      s1_legal_d = legal_in;
    end
    if (adv2) begin
      ov_d  = s1_v_q;
      d_d   = dec;
      err_d = ~s1_legal_q;
    end
    if (ERR_CLR) begin
      cnt_d = '0;
    end else if (ov_q & OUT_READY & err_q & (cnt_q != CMAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q_q     <= '0;
      s1_v_q     <= 1'b0;
      s1_legal_q <= 1'b0;
      ov_q       <= 1'b0;
      d_q        <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q_q     <= s1_q_d;
      s1_v_q     <= s1_v_d;
      s1_legal_q <= s1_legal_d;
      ov_q       <= ov_d;
      d_q        <= d_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign IN_READY  = adv1;
  assign OUT_VALID = ov_q;
  assign D         = d_q;
  assign ERR       = err_q;
  assign ERR_CNT   = cnt_q;

endmodule

// File: tb/tb_thermo_dec.sv
// Bench for thermo_dec: vector table, directed flow-control sequences,
// and a random sweep against a popcount/shift-pattern reference.
module tb_thermo_dec;

  logic        CLK = 0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] Q;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [3:0]  D;
  logic        ERR;
  logic        ERR_CLR;
  logic [1:0]  ERR_CNT;

  thermo_dec #(.D_WIDTH(4), .Q_WIDTH(16), .CNT_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Q(Q),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .D(D), .ERR(ERR),
    .ERR_CLR(ERR_CLR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] d;
    bit         err;
  } exp_t;

  typedef struct {
    logic [15:0] q;
    logic [3:0]  d;
    bit          err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  exp_t sb[$];
  logic [1:0] m_cnt = 0;
  bit         hold_pend = 0;
  logic [3:0] hold_d;
  logic       hold_e;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t ref_of(input logic [15:0] q);
    exp_t e;
    int   pop;
    logic [15:0] ones;
    ones  = 16'hFFFF;
    pop   = $countones(q);
    e.d   = (pop == 0) ? 4'd15 : 4'(16 - pop);
    e.err = 1;
    for (int k = 0; k < 16; k++)
      if (q == (ones << k)) e.err = 0;
    return e;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle while inputs are stable.
  always @(negedge CLK) begin
    if (mon_en) begin
      bit   err_now;
      exp_t e;
      err_now = 0;
      chk(IN_READY == ((sb.size() < 2) || OUT_READY), "in_ready",
          IN_READY, ((sb.size() < 2) || OUT_READY));
      if (sb.size() == 0)
        chk(!OUT_VALID, "ov_when_empty", OUT_VALID, 0);
      chk(ERR_CNT == m_cnt, "err_cnt", ERR_CNT, m_cnt);
      if (hold_pend && OUT_VALID)
        chk(D == hold_d && ERR == hold_e, "hold_stable",
            {D, 3'b0, ERR}, {hold_d, 3'b0, hold_e});
      if (RST) begin
        sb.delete();
        m_cnt     = 0;
        hold_pend = 0;
      end else begin
        if (OUT_VALID && OUT_READY) begin
          if (sb.size() == 0) begin
            chk(0, "spurious_out", D, 0);
          end else begin
            e = sb.pop_front();
            chk(D == e.d, "sb_d", D, e.d);
            chk(ERR == e.err, "sb_err", ERR, e.err);
            err_now = e.err;
          end
        end
        if (IN_VALID && IN_READY) sb.push_back(ref_of(Q));
        hold_pend = OUT_VALID && !OUT_READY;
        hold_d    = D;
        hold_e    = ERR;
        if (ERR_CLR) m_cnt = 0;
        else if (err_now && m_cnt != 2'd3) m_cnt = m_cnt + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=0 exp=1");
    $fatal(1, "timeout");
  end

  localparam int NV = 10;
  vec_t tab[NV];
  logic [3:0] outs[$];
  bit acc;
  logic [15:0] ones;
  int li;

  initial begin
    tab[0] = '{16'hFFFF, 4'd0,  0};
    tab[1] = '{16'hFFF8, 4'd3,  0};
    tab[2] = '{16'h8000, 4'd15, 0};
    tab[3] = '{16'hFFD8, 4'd4,  1};
    tab[4] = '{16'h0000, 4'd15, 1};
    tab[5] = '{16'h7FFF, 4'd1,  1};
    tab[6] = '{16'hFFFE, 4'd1,  0};
    tab[7] = '{16'hC000, 4'd14, 0};
    tab[8] = '{16'h0001, 4'd15, 1};
    tab[9] = '{16'hAAAA, 4'd8,  1};

    RST = 1; IN_VALID = 0; Q = 0; OUT_READY = 1; ERR_CLR = 0;
    repeat (2) cyc();
    chk(OUT_VALID == 0, "rst_ov", OUT_VALID, 0);
    chk(D == 0, "rst_d", D, 0);
    chk(ERR == 0, "rst_err", ERR, 0);
    chk(ERR_CNT == 0, "rst_cnt", ERR_CNT, 0);
    chk(IN_READY == 1, "rst_in_ready", IN_READY, 1);
    RST = 0;
    mon_en = 1;

    // Back-to-back table: each result appears two edges after its input.
    for (int c = 0; c <= NV; c++) begin
      if (c < NV) begin
        IN_VALID = 1;
        Q = tab[c].q;
      end else begin
        IN_VALID = 0;
      end
      cyc();
      if (c >= 1) begin
        chk(OUT_VALID == 1, "tab_ov", OUT_VALID, 1);
        chk(D == tab[c-1].d, "tab_d", D, tab[c-1].d);
        chk(ERR == tab[c-1].err, "tab_err", ERR, tab[c-1].err);
      end
    end
    cyc();
    chk(ERR_CNT == 3, "cnt_saturated", ERR_CNT, 3);

    // Clear wins over an errored transfer in the same cycle.
    IN_VALID = 1; Q = 16'h0000;
    cyc();
    IN_VALID = 0;
    cyc();
    chk(OUT_VALID && ERR, "clr_setup", {OUT_VALID, ERR}, 2'b11);
    chk(ERR_CNT == 3, "clr_before", ERR_CNT, 3);
    ERR_CLR = 1;
    cyc();
    ERR_CLR = 0;
    chk(ERR_CNT == 0, "clr_priority", ERR_CNT, 0);

    // Back-pressure: two words fill the pipe, the third waits.
    OUT_READY = 0; IN_VALID = 1; Q = 16'hFFF8;
    cyc();
    Q = 16'hFF80;
    cyc();
    Q = 16'hFE00;
    chk(IN_READY == 0, "bp_full", IN_READY, 0);
    repeat (3) begin
      cyc();
      chk(IN_READY == 0, "bp_ready", IN_READY, 0);
      chk(OUT_VALID && D == 3, "bp_hold_d", D, 3);
    end
    OUT_READY = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (OUT_VALID && OUT_READY) outs.push_back(D);
      acc = IN_VALID && IN_READY;
      cyc();
      if (acc) IN_VALID = 0;
    end
    chk(outs.size() == 3, "bp_count", outs.size(), 3);
    if (outs.size() == 3) begin
      chk(outs[0] == 3, "bp_out0", outs[0], 3);
      chk(outs[1] == 7, "bp_out1", outs[1], 7);
      chk(outs[2] == 9, "bp_out2", outs[2], 9);
    end

    // Reset with both stages full.
    IN_VALID = 1; Q = 16'h0001;
    cyc();
    IN_VALID = 0;
    repeat (2) cyc();
    chk(ERR_CNT == 1, "pre_rst_cnt", ERR_CNT, 1);
    OUT_READY = 0; IN_VALID = 1; Q = 16'h0000;
    cyc();
    Q = 16'hFFFF;
    cyc();
    IN_VALID = 0;
    chk(IN_READY == 0 && OUT_VALID == 1, "pre_rst_full",
        {IN_READY, OUT_VALID}, 2'b01);
    RST = 1;
    cyc();
    RST = 0;
    chk(OUT_VALID == 0, "mid_rst_ov", OUT_VALID, 0);
    chk(IN_READY == 1, "mid_rst_ready", IN_READY, 1);
    chk(ERR_CNT == 0, "mid_rst_cnt", ERR_CNT, 0);
    OUT_READY = 1;
    repeat (4) begin
      cyc();
      chk(OUT_VALID == 0, "rst_discard", OUT_VALID, 0);
    end

    // Random sweep, cycling through every legal code.
    ones = 16'hFFFF;
    li = 0;
    for (int n = 0; n < 600; n++) begin
      IN_VALID = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        Q = ones << (li % 16);
        li++;
      end else begin
        Q = 16'($urandom);
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
      ERR_CLR = ($urandom_range(0, 15) == 0);
      cyc();
    end
    IN_VALID = 0; OUT_READY = 1; ERR_CLR = 0;
    for (int w = 0; w < 10 && sb.size() != 0; w++) cyc();
    chk(sb.size() == 0, "drain", sb.size(), 0);
    chk(li >= 16, "legal_cover", li, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermo_dec.md
Name: thermo_dec

Overview:
- Pipelined thermometer-to-binary decoder. It is the receive-side counterpart of the team's thermometer encoder.
- Accepted code convention: Q[i]=1 for every i >= D, so zeros sit at the LSB end, ones at the MSB end, and Q[Q_WIDTH-1] is always 1.
- Recovers D with bubble tolerance (count-based), flags non-monotonic or illegal codes, and keeps a saturating error count.
- Valid/ready streaming on both sides, 2-stage pipeline. Intended for flash-ADC and DAC loopback paths.

Parameters:
- D_WIDTH, 4: binary output width.
- Q_WIDTH, 2**D_WIDTH: thermometer input width. Must equal 2**D_WIDTH.
- CNT_WIDTH, 8: width of the error counter.

Ports:
- CLK, in, 1: single clock. All logic is rising-edge.
- RST, in, 1: synchronous, active-high reset.
- IN_VALID, in, 1: Q is valid.
- IN_READY, out, 1: block can accept Q this cycle.
- Q, in, Q_WIDTH: thermometer code.
- OUT_VALID, out, 1: D and ERR are valid.
- OUT_READY, in, 1: downstream accepts D and ERR.
- D, out, D_WIDTH: decoded value.
- ERR, out, 1: code accompanying D was not a legal thermometer code.
- ERR_CLR, in, 1: clear ERR_CNT.
- ERR_CNT, out, CNT_WIDTH: saturating count of errored transfers.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - OUT_VALID=0, D=0, ERR=0, ERR_CNT=0, both stages empty.
  - IN_READY=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight words; nothing is emitted for them.
- Transfers:
  - Input transfer when IN_VALID & IN_READY at a CLK edge.
  - Output transfer when OUT_VALID & OUT_READY.
  - D and ERR hold stable while OUT_VALID=1 and OUT_READY=0.
- Stage 1 (S1):
  - Registers Q, a valid bit s1_v, and the legality flag.
  - Legal means Q[Q_WIDTH-1]=1 and no i with Q[i]=1 & Q[i+1]=0, i.e. Q is of the form 1..10..0.
- Stage 2 (S2):
  - Registers D, ERR, and the valid bit (OUT_VALID).
  - pop = number of ones in the S1 Q, range 0..Q_WIDTH.
  - D = Q_WIDTH - pop, computed in D_WIDTH+1 bits.
  - pop=0 (all-zero input) saturates D to Q_WIDTH-1.
  - ERR = not legal.
  - For legal codes D equals the index of the lowest 1.
- Flow control:
  - adv2 = ~OUT_VALID | OUT_READY.
  - adv1 = ~s1_v | adv2.
  - IN_READY = adv1, combinational from registered state and OUT_READY. There is no combinational path from IN_VALID.
  - When adv2: OUT_VALID <= s1_v, and D/ERR are loaded from S1.
  - When adv1: s1_v <= IN_VALID, and Q is loaded.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to OUT_VALID=1, given OUT_READY=1.
  - Full throughput: 1 word per cycle.
  - Maximum occupancy is 2 words, with order preserved.
- Error counter:
  - ERR_CNT increments on each output transfer with ERR=1.
  - Saturates at 2**CNT_WIDTH-1, no wrap.
  - ERR_CLR=1 sets ERR_CNT to 0 and takes priority over a same-cycle increment; that error is not counted.
- No X propagation: the S1 Q register may hold stale data when s1_v=0, but the outputs are gated only by the valid bits.

Test Plan (D_WIDTH=4, Q_WIDTH=16):
- Reset/legal decode, OUT_READY=1: Q=16'hFFFF, 16'hFFF8, 16'h8000 on consecutive cycles -> D=0, 3, 15, ERR=0, each 2 cycles after input, back-to-back OUT_VALID.
- Bubble: Q=16'hFFD8 (pop=12) -> D=4, ERR=1, ERR_CNT 0->1. Q=16'h0000 -> D=15, ERR=1, ERR_CNT=2.
- Back-pressure: OUT_READY=0, offer 3 words (3, 7, 9 as codes) -> IN_READY drops after 2 accepted. Release OUT_READY -> D=3, 7, 9 in order, D stable while stalled, no loss or duplication.
- Saturation/clear, CNT_WIDTH=2: 5 errored transfers -> ERR_CNT=3. ERR_CLR asserted in the same cycle as an errored transfer -> ERR_CNT=0 the next cycle.
- Reset mid-stream: both stages full, assert RST one cycle -> OUT_VALID=0, IN_READY=1 next cycle, the discarded words never appear, ERR_CNT=0.
- Random sweep: all 16 legal codes plus random illegal codes with random IN_VALID/OUT_READY -> scoreboard matches D=16-pop (saturated) and the ERR legality rule.
